// File: rtl/tx_packet_scheduler.sv
// Transmit scheduler: watches four message words, detects changes and serialises
// them as single-cycle UART FIFO writes with round-robin fairness, a one-cycle
// gap after every write, and a periodic keepalive re-send of the connection word.
module tx_packet_scheduler #(
    parameter int unsigned KEEPALIVE_CYCLES = 650_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_game_state_sel,
    input  logic [7:0] data_shoot_control,
    input  logic [7:0] data_mouse_control,
    input  logic [7:0] data_score_control,
    input  logic       tx_full,
    output logic [7:0] w_data,
    output logic       wr_uart,
    output logic       busy
);

    localparam logic [19:0] KaLast = 20'(KEEPALIVE_CYCLES - 1);

    typedef enum logic [0:0] {StIdle, StGap} state_e;

    state_e          state_q, state_d;
    logic [3:0][7:0] data_in;
    logic [3:0][7:0] last_sent_q, last_sent_d;
    logic [3:0]      pending_q, pending_d;
    logic [1:0]      rr_ptr_q, rr_ptr_d;
    logic [19:0]     ka_cnt_q, ka_cnt_d;
    logic [7:0]      w_data_q, w_data_d;
    logic            wr_uart_q, wr_uart_d;
    logic            grant_valid;
    logic [1:0]      grant_idx;
    logic [1:0]      cand;

    // Index 0 is the connection word, which is also the keepalive source.
    assign data_in = {data_score_control, data_mouse_control,
                      data_shoot_control, data_game_state_sel};

    // Round-robin arbiter: first pending source at or after rr_ptr (mod 4).
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = rr_ptr_q;
        cand        = rr_ptr_q;
        // Walk offsets high to low so the smallest offset wins.
        for (int k = 3; k >= 0; k--) begin
            cand = rr_ptr_q + 2'(k);
            if (pending_q[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Next-state: change detection, keepalive, then grant (grant clears last).
    always_comb begin
        state_d     = state_q;
        last_sent_d = last_sent_q;
        pending_d   = pending_q;
        rr_ptr_d    = rr_ptr_q;
        w_data_d    = w_data_q;
        wr_uart_d   = 1'b0;
        ka_cnt_d    = ka_cnt_q + 20'd1;

        for (int i = 0; i < 4; i++) begin
            if (data_in[i] != last_sent_q[i]) begin
                if (data_in[i][2:0] == 3'b000) begin
                    // "No message" words are absorbed without transmission.
                    last_sent_d[i] = data_in[i];
                    pending_d[i]   = 1'b0;
                end else begin
                    pending_d[i] = 1'b1;
                end
            end
        end

        if (wr_uart_q) begin
            ka_cnt_d = '0;
        end else if (ka_cnt_q == KaLast && data_in[0][2:0] != 3'b000) begin
            pending_d[0] = 1'b1;
            ka_cnt_d     = '0;
        end

        unique case (state_q)
            StIdle: begin
                if (!tx_full && grant_valid) begin
                    state_d                = StGap;
                    w_data_d               = data_in[grant_idx];
                    wr_uart_d              = 1'b1;
                    last_sent_d[grant_idx] = data_in[grant_idx];
                    pending_d[grant_idx]   = 1'b0;
                    rr_ptr_d               = grant_idx + 2'd1;
                end
            end
            StGap: begin
                // Spacing cycle covers the one-cycle lag of tx_full.
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            last_sent_q <= '0;
            pending_q   <= '0;
            rr_ptr_q    <= '0;
            ka_cnt_q    <= '0;
            w_data_q    <= '0;
            wr_uart_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_sent_q <= last_sent_d;
            pending_q   <= pending_d;
            rr_ptr_q    <= rr_ptr_d;
            ka_cnt_q    <= ka_cnt_d;
            w_data_q    <= w_data_d;
            wr_uart_q   <= wr_uart_d;
        end
    end

    assign w_data  = w_data_q;
    assign wr_uart = wr_uart_q;
    assign busy    = (|pending_q) || (state_q == StGap);

endmodule

// File: tb/tb_tx_packet_scheduler.sv
// Bench for tx_packet_scheduler: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the scheduling rules.
module tb_tx_packet_scheduler;

    localparam int K = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_game_state_sel, data_shoot_control;
    logic [7:0] data_mouse_control, data_score_control;
    logic       tx_full;
    logic [7:0] w_data;
    logic       wr_uart;
    logic       busy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int t0;

    // Reference model state.
    logic [7:0] m_last[4];
    bit         m_pend[4];
    int         m_ptr;
    int         m_ka;
    bit         m_gap;
    bit         m_wr;
    logic [7:0] m_wd;

    // Observed writes (value and cycle number).
    logic [7:0] wlog_v[$];
    int         wlog_c[$];

    logic [7:0] exp2[4] = '{8'h09, 8'h12, 8'h1B, 8'h24};

    tx_packet_scheduler #(.KEEPALIVE_CYCLES(K)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .data_game_state_sel (data_game_state_sel),
        .data_shoot_control  (data_shoot_control),
        .data_mouse_control  (data_mouse_control),
        .data_score_control  (data_score_control),
        .tx_full             (tx_full),
        .w_data              (w_data),
        .wr_uart             (wr_uart),
        .busy                (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply the scheduling rules for one rising edge to the model.
    task automatic model_edge();
        logic [7:0] d[4];
        int  g;
        bit  ka_fire;
        d = '{data_game_state_sel, data_shoot_control, data_mouse_control, data_score_control};
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                m_last[i] = 8'h00;
                m_pend[i] = 1'b0;
            end
            m_ptr = 0; m_ka = 0; m_gap = 0; m_wr = 0; m_wd = 8'h00;
            return;
        end
        g = -1;
        if (!m_gap && !tx_full) begin
            for (int k = 0; k < 4; k++) begin
                if (g < 0 && m_pend[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
            end
        end
        ka_fire = !m_wr && (m_ka == K - 1) && (d[0][2:0] != 3'b000);
        if (m_wr || ka_fire) m_ka = 0;
        else m_ka = (m_ka + 1) % (1 << 20);
        for (int i = 0; i < 4; i++) begin
            if (d[i] != m_last[i]) begin
                if (d[i][2:0] == 3'b000) begin
                    m_last[i] = d[i];
                    m_pend[i] = 1'b0;
                end else begin
                    m_pend[i] = 1'b1;
                end
            end
        end
        if (ka_fire) m_pend[0] = 1'b1;
        if (g >= 0) begin
            m_wd      = d[g];
            m_last[g] = d[g];
            m_pend[g] = 1'b0;
            m_ptr     = (g + 1) % 4;
        end
        m_wr  = (g >= 0);
        m_gap = (g >= 0);
    endtask

    // One clock: update the model at the edge, compare outputs 1 time unit later.
    task automatic step();
        bit exp_busy;
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        exp_busy = m_gap || m_pend[0] || m_pend[1] || m_pend[2] || m_pend[3];
        chk("wr_uart", wr_uart, m_wr);
        chk("w_data", w_data, m_wd);
        chk("busy", busy, exp_busy);
        if (wr_uart) begin
            wlog_v.push_back(w_data);
            wlog_c.push_back(cyc);
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_log();
        wlog_v.delete();
        wlog_c.delete();
    endtask

    function automatic logic [7:0] rnd_word();
        logic [7:0] w;
        w = 8'($urandom);
        if ($urandom_range(0, 3) == 0) w[2:0] = 3'b000;
        return w;
    endfunction

    initial begin
        rst = 1'b0;
        tx_full = 1'b0;
        data_game_state_sel = 8'h00;
        data_shoot_control  = 8'h00;
        data_mouse_control  = 8'h00;
        data_score_control  = 8'h00;

        // Reset state.
        steps(3);
        chk("rst_w_data", w_data, 8'h00);
        chk("rst_wr_uart", wr_uart, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b1;
        steps(2);

        // Single change: one write two cycles later, nothing after.
        clear_log();
        t0 = cyc;
        data_shoot_control = 8'h2B;
        steps(2);
        chk("t1_wr", wr_uart, 1'b1);
        chk("t1_data", w_data, 8'h2B);
        steps(20);
        chk("t1_count", wlog_v.size(), 1);

        // Simultaneous changes after reset: round-robin from source 0, 2 cycles apart.
        rst = 1'b0;
        data_shoot_control = 8'h00;
        steps(2);
        rst = 1'b1;
        clear_log();
        t0 = cyc;
        data_game_state_sel = 8'h09;
        data_shoot_control  = 8'h12;
        data_mouse_control  = 8'h1B;
        data_score_control  = 8'h24;
        steps(12);
        chk("t2_count", wlog_v.size(), 4);
        for (int i = 0; i < wlog_v.size() && i < 4; i++) begin
            chk("t2_val", wlog_v[i], exp2[i]);
            if (i == 0) chk("t2_first", wlog_c[0] - t0, 2);
            else chk("t2_gap", wlog_c[i] - wlog_c[i - 1], 2);
        end
        data_game_state_sel = 8'h08;
        steps(4);

        // Stall: only the latest mouse value goes out after release.
        clear_log();
        tx_full = 1'b1;
        step();
        data_mouse_control = 8'h0A;
        steps(30);
        data_mouse_control = 8'h52;
        steps(30);
        data_mouse_control = 8'h7A;
        steps(39);
        chk("t3_stall", wlog_v.size(), 0);
        tx_full = 1'b0;
        steps(10);
        chk("t3_count", wlog_v.size(), 1);
        if (wlog_v.size() > 0) chk("t3_val", wlog_v[0], 8'h7A);

        // Opcode-0 word is absorbed; the next real word is sent.
        clear_log();
        data_score_control = 8'h40;
        steps(10);
        chk("t4_silent", wlog_v.size(), 0);
        data_score_control = 8'h43;
        steps(6);
        chk("t4_count", wlog_v.size(), 1);
        if (wlog_v.size() > 0) chk("t4_val", wlog_v[0], 8'h43);

        // Keepalive: static connection word re-sent every K + 2 cycles.
        clear_log();
        t0 = cyc;
        data_game_state_sel = 8'h01;
        steps(60);
        chk("t5_count", wlog_v.size(), 4);
        for (int i = 0; i < wlog_v.size(); i++) begin
            chk("t5_val", wlog_v[i], 8'h01);
            if (i == 0) chk("t5_first", wlog_c[0] - t0, 2);
            else chk("t5_period", wlog_c[i] - wlog_c[i - 1], K + 2);
        end

        // Reset during the write cycle; mouse word re-sent after release.
        data_game_state_sel = 8'h00;
        data_shoot_control  = 8'h00;
        data_score_control  = 8'h00;
        steps(4);
        data_mouse_control = 8'h0A;
        steps(2);
        chk("t6_wr", wr_uart, 1'b1);
        rst = 1'b0;
        step();
        chk("t6_rst_wr", wr_uart, 1'b0);
        chk("t6_rst_data", w_data, 8'h00);
        rst = 1'b1;
        clear_log();
        t0 = cyc;
        steps(3);
        chk("t6_count", wlog_v.size(), 1);
        if (wlog_v.size() > 0) begin
            chk("t6_val", wlog_v[0], 8'h0A);
            chk("t6_lat", wlog_c[0] - t0, 2);
        end

        // Random traffic, busy phase.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) data_game_state_sel = rnd_word();
            if ($urandom_range(0, 7) == 0) data_shoot_control  = rnd_word();
            if ($urandom_range(0, 7) == 0) data_mouse_control  = rnd_word();
            if ($urandom_range(0, 7) == 0) data_score_control  = rnd_word();
            tx_full = ($urandom_range(0, 9) < 3);
            rst     = ($urandom_range(0, 99) != 0);
            step();
        end

        // Random traffic, sparse phase so keepalives fire between changes.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 63) == 0) data_game_state_sel = rnd_word();
            if ($urandom_range(0, 63) == 0) data_shoot_control  = rnd_word();
            if ($urandom_range(0, 63) == 0) data_mouse_control  = rnd_word();
            if ($urandom_range(0, 63) == 0) data_score_control  = rnd_word();
            tx_full = ($urandom_range(0, 19) == 0);
            rst     = ($urandom_range(0, 499) != 0);
            step();
        end
        rst = 1'b1;
        tx_full = 1'b0;
        steps(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
